// File: rtl/boss_aggro_ctrl.sv
// Per-player boss threat tracker: rate-limited hit accumulation, frame-based decay,
// death clearing and a hysteresis-filtered chase target flag for the HUD.
module boss_aggro_ctrl #(
  parameter int HIT_AGGRO      = 4,
  parameter int COOLDOWN_TICKS = 20,
  parameter int DECAY_TICKS    = 60,
  parameter int SWITCH_MARGIN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       char_hit,
  input  logic       player_2_hit,
  input  logic       char_alive,
  input  logic       player_2_alive,
  output logic [3:0] char_aggro,
  output logic [3:0] player_2_aggro,
  output logic       aggro_target
);

  localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);
  localparam int DC_W = $clog2(DECAY_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state;
  logic [CD_W-1:0] char_cd;
  logic [CD_W-1:0] p2_cd;
  logic [DC_W-1:0] decay_cnt;

  logic            char_hit_ok;
  logic            p2_hit_ok;
  logic            dec;
  logic            to_p2;
  logic            to_char;
  logic [4:0]      char_5;
  logic [4:0]      p2_5;

  // Signed headroom lets a decay on an empty meter clamp at 0 instead of wrapping.
  function automatic logic [3:0] next_aggro(input logic [3:0] a, input logic hit,
                                            input logic d, input logic alive);
    logic signed [5:0] s;
    s = signed'({2'b00, a});
    if (hit) s = s + signed'(6'(HIT_AGGRO));
    if (d)   s = s - 6'sd1;
    if (!alive)          return 4'd0;
    else if (s < 6'sd0)  return 4'd0;
    else if (s > 6'sd15) return 4'd15;
    else                 return s[3:0];
  endfunction

  function automatic logic [CD_W-1:0] next_cd(input logic [CD_W-1:0] cd, input logic hit_ok,
                                              input logic tick, input logic alive);
    if (!alive)                       return '0;
    else if (hit_ok)                  return CD_W'(COOLDOWN_TICKS);
    else if (tick && (cd != '0))      return cd - CD_W'(1);
    else                              return cd;
  endfunction

  always_comb begin
    char_hit_ok = char_hit && char_alive && (char_cd == '0);
    p2_hit_ok   = player_2_hit && player_2_alive && (p2_cd == '0);
    dec         = frame_tick && (decay_cnt == DC_W'(DECAY_TICKS - 1));
    char_5      = {1'b0, char_aggro};
    p2_5        = {1'b0, player_2_aggro};
    to_p2       = (p2_5 >= char_5 + 5'(SWITCH_MARGIN)) || (!char_alive && player_2_alive);
    to_char     = (char_5 >= p2_5 + 5'(SWITCH_MARGIN)) || (!player_2_alive && char_alive);
  end

  // Single FSM block; all tracking only advances in RUN while game_active is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      char_aggro     <= '0;
      player_2_aggro <= '0;
      char_cd        <= '0;
      p2_cd          <= '0;
      decay_cnt      <= '0;
      aggro_target   <= 1'b0;
    end else if (game_active == 2'd0) begin
      state          <= IDLE;
      char_aggro     <= '0;
      player_2_aggro <= '0;
      char_cd        <= '0;
      p2_cd          <= '0;
      decay_cnt      <= '0;
      aggro_target   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (game_active == 2'd1) state <= RUN;
        end
        RUN: begin
          if (game_active != 2'd1) begin
            state <= HOLD;
          end else begin
            char_aggro     <= next_aggro(char_aggro, char_hit_ok, dec, char_alive);
            player_2_aggro <= next_aggro(player_2_aggro, p2_hit_ok, dec, player_2_alive);
            char_cd        <= next_cd(char_cd, char_hit_ok, frame_tick, char_alive);
            p2_cd          <= next_cd(p2_cd, p2_hit_ok, frame_tick, player_2_alive);
            if (frame_tick) decay_cnt <= dec ? '0 : decay_cnt + DC_W'(1);
            // With both players dead the indicator keeps pointing where it was.
            if (char_alive || player_2_alive) begin
              if (!aggro_target && to_p2)      aggro_target <= 1'b1;
              else if (aggro_target && to_char) aggro_target <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (game_active == 2'd1) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boss_aggro_ctrl.sv
// Directed bench for boss_aggro_ctrl with hand-computed aggro/target expectations.
module tb_boss_aggro_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [1:0] game_active;
  logic       char_hit;
  logic       player_2_hit;
  logic       char_alive;
  logic       player_2_alive;
  logic [3:0] char_aggro;
  logic [3:0] player_2_aggro;
  logic       aggro_target;

  int checks = 0;
  int errors = 0;

  boss_aggro_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .game_active    (game_active),
    .char_hit       (char_hit),
    .player_2_hit   (player_2_hit),
    .char_alive     (char_alive),
    .player_2_alive (player_2_alive),
    .char_aggro     (char_aggro),
    .player_2_aggro (player_2_aggro),
    .aggro_target   (aggro_target)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given pulses held across the edge; outputs settle by the return.
  task automatic applyStimulus(input logic c, input logic p, input logic t);
    char_hit     = c;
    player_2_hit = p;
    frame_tick   = t;
    @(posedge clk);
    #1;
    char_hit     = 1'b0;
    player_2_hit = 1'b0;
    frame_tick   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic restart();
    game_active = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    game_active = 2'd1;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    frame_tick     = 1'b0;
    game_active    = 2'd0;
    char_hit       = 1'b0;
    player_2_hit   = 1'b0;
    char_alive     = 1'b1;
    player_2_alive = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_char", char_aggro, 4'd0);
    checkOutput("reset_p2", player_2_aggro, 4'd0);
    checkOutput("reset_target", {3'b0, aggro_target}, 4'd0);

    $display("[TB] first hit");
    game_active = 2'd1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hit1_char", char_aggro, 4'd4);
    checkOutput("hit1_p2", player_2_aggro, 4'd0);
    checkOutput("hit1_target", {3'b0, aggro_target}, 4'd0);

    $display("[TB] cooldown");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cd_burst", char_aggro, 4'd4);
    ticks(19);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cd_19ticks", char_aggro, 4'd4);
    ticks(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cd_20ticks", char_aggro, 4'd8);

    $display("[TB] saturation");
    restart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(20);
    checkOutput("sat_decay60", char_aggro, 4'd11);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_15", char_aggro, 4'd15);
    ticks(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_nowrap", char_aggro, 4'd15);
    ticks(39);
    checkOutput("sat_59", char_aggro, 4'd15);
    ticks(1);
    checkOutput("sat_decay", char_aggro, 4'd14);

    $display("[TB] hit with decay");
    restart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(180);
    checkOutput("dec_to1", char_aggro, 4'd1);
    ticks(59);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("hit_and_dec", char_aggro, 4'd4);
    checkOutput("dec_floor", player_2_aggro, 4'd0);

    $display("[TB] target switch");
    restart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(160);
    checkOutput("t5_char5", char_aggro, 4'd5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_p2_4", player_2_aggro, 4'd4);
    ticks(20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_p2_8", player_2_aggro, 4'd8);
    checkOutput("t5_tgt_lag", {3'b0, aggro_target}, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_tgt_p2", {3'b0, aggro_target}, 4'd1);
    char_alive = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_dead_char", char_aggro, 4'd0);
    checkOutput("t5_tgt_hold", {3'b0, aggro_target}, 4'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_dead_hit", char_aggro, 4'd0);
    char_alive = 1'b1;

    $display("[TB] freeze and clear");
    game_active = 2'd2;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("hold_char", char_aggro, 4'd0);
    checkOutput("hold_p2", player_2_aggro, 4'd8);
    ticks(80);
    checkOutput("hold_ticks", player_2_aggro, 4'd8);
    game_active = 2'd1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    player_2_alive = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("p2_dead", player_2_aggro, 4'd0);
    checkOutput("p2_dead_tgt", {3'b0, aggro_target}, 4'd0);
    player_2_alive = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("p2_revive_hit", player_2_aggro, 4'd4);
    game_active = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_p2", player_2_aggro, 4'd0);
    checkOutput("clear_char", char_aggro, 4'd0);

    game_active = 2'd1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_char", char_aggro, 4'd4);
    checkOutput("both_p2", player_2_aggro, 4'd4);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_char", char_aggro, 4'd0);
    checkOutput("async_p2", player_2_aggro, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_char", char_aggro, 4'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
